// File: rtl/uart_msg_pkg.sv
// Shared encodings and ASCII helpers for the UART message scheduler.
package uart_msg_pkg;

  // Message source selected for the message in flight.
  typedef enum logic [1:0] {
    SRC_ERR  = 2'd0,
    SRC_EVT  = 2'd1,
    SRC_STAT = 2'd2
  } src_t;

  // Scheduler FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Message lengths in bytes, CR/LF included.
  localparam logic [3:0] LEN_ERR       = 4'd9;
  localparam logic [3:0] LEN_EVT       = 4'd8;
  localparam logic [3:0] LEN_STAT_UP   = 4'd13;
  localparam logic [3:0] LEN_STAT_LONG = 4'd15;
  localparam logic [3:0] LEN_STAT_INV  = 4'd12;

  // Number of STAT bytes that are not direction text ("F:nn,DIR:" plus CR LF).
  localparam logic [3:0] STAT_FIXED    = 4'd11;
  localparam logic [3:0] STAT_PREFIX   = 4'd9;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'd48;

  // Direction codes from the elevator FSM.
  localparam logic [1:0] DIR_UP   = 2'b00;
  localparam logic [1:0] DIR_STOP = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_INV  = 2'b11;

  function automatic logic [7:0] tens_char(input logic [5:0] v);
    return ASCII_ZERO + 8'(v / 6'd10);
  endfunction

  function automatic logic [7:0] ones_char(input logic [5:0] v);
    return ASCII_ZERO + 8'(v % 6'd10);
  endfunction

  // Total STAT message length for a given direction code.
  function automatic logic [3:0] stat_len(input logic [1:0] dir);
    logic [3:0] l;
    case (dir)
      DIR_UP:  l = LEN_STAT_UP;
      DIR_INV: l = LEN_STAT_INV;
      default: l = LEN_STAT_LONG;
    endcase
    return l;
  endfunction

  // Character k of the direction word (UP, STOP, DOWN or ?).
  function automatic logic [7:0] dir_char(input logic [1:0] dir, input logic [3:0] k);
    logic [7:0] c;
    c = "?";
    case (dir)
      DIR_UP:   c = (k == 4'd0) ? "U" : "P";
      DIR_STOP: case (k)
                  4'd0:    c = "S";
                  4'd1:    c = "T";
                  4'd2:    c = "O";
                  default: c = "P";
                endcase
      DIR_DOWN: case (k)
                  4'd0:    c = "D";
                  4'd1:    c = "O";
                  4'd2:    c = "W";
                  default: c = "N";
                endcase
      default:  c = "?";
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_sec_tick.sv
// Free-running status-period counter: one-cycle tick on the cycle it wraps.
module uart_sec_tick
  import uart_msg_pkg::*;
#(
  parameter int T_TICK = 50_000_000,
  parameter int TICK_W = 26
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(T_TICK - 1);

  logic [TICK_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..T_TICK-1 and wrap; keeps running regardless of pause.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + TICK_W'(1);
  end

endmodule

// File: rtl/uart_msg_sched.sv
// Shares one byte serializer among error, arrival and periodic status messages.
module uart_msg_sched
  import uart_msg_pkg::*;
#(
  parameter int T_TICK = 50_000_000,
  parameter int TICK_W = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] FLOOR,
  input  logic [1:0] DIR,
  input  logic       ERR_REQ,
  input  logic       EVT_REQ,
  input  logic [5:0] EVT_FLOOR,
  input  logic       TX_PAUSE,
  output logic [7:0] TXB_DATA,
  output logic       TXB_VALID,
  input  logic       TXB_READY,
  output logic       BUSY
);

  logic       tick;
  logic [1:0] state;
  logic       err_pend, evt_pend, stat_pend;
  logic [5:0] evt_floor;
  src_t       src, sel_src;
  logic [3:0] len, sel_len, idx;
  logic [5:0] snap_floor;
  logic [1:0] snap_dir;
  logic       xfer, last_byte, done, abort;
  logic       clr_err, clr_evt, clr_stat;
  logic [3:0] dir_len, dir_k;
  logic [7:0] cur_byte;

  uart_sec_tick #(.T_TICK(T_TICK), .TICK_W(TICK_W)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  assign xfer      = (state == ST_SEND) && TXB_READY;
  assign last_byte = (idx == len - 4'd1);
  assign done      = xfer && last_byte;
  assign abort     = xfer && !last_byte && TX_PAUSE;

  // A dropped status message counts as served; ERR/EVT survive an abort.
  assign clr_err  = done && (src == SRC_ERR);
  assign clr_evt  = done && (src == SRC_EVT);
  assign clr_stat = (done || abort) && (src == SRC_STAT);

  // Pending request flags; a new request outranks a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_pend  <= 1'b0;
      evt_pend  <= 1'b0;
      stat_pend <= 1'b0;
      evt_floor <= '0;
    end else begin
      err_pend  <= ERR_REQ | (err_pend  & ~clr_err);
      evt_pend  <= EVT_REQ | (evt_pend  & ~clr_evt);
      stat_pend <= tick    | (stat_pend & ~clr_stat);
      if (EVT_REQ) evt_floor <= EVT_FLOOR;
    end
  end

  // Fixed priority ERR > EVT > STAT, evaluated when the message is loaded.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_src = SRC_STAT;
    sel_len = stat_len(DIR);
    if (err_pend) begin
      sel_src = SRC_ERR;
      sel_len = LEN_ERR;
    end else if (evt_pend) begin
      sel_src = SRC_EVT;
      sel_len = LEN_EVT;
    end
  end

  // Scheduler FSM: IDLE -> LOAD (snapshot) -> SEND (one byte per handshake).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      src        <= SRC_STAT;
      len        <= '0;
      idx        <= '0;
      snap_floor <= '0;
      snap_dir   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!TX_PAUSE && (err_pend || evt_pend || stat_pend)) state <= ST_LOAD;
        end
        ST_LOAD: begin
          src        <= sel_src;
          len        <= sel_len;
          snap_floor <= (sel_src == SRC_EVT) ? evt_floor : FLOOR;
          snap_dir   <= DIR;
          idx        <= '0;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          // Pause is only honoured at a byte boundary, i.e. on a handshake.
          if (xfer) begin
            if (last_byte || TX_PAUSE) state <= ST_IDLE;
            else                       idx   <= idx + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dir_len = stat_len(snap_dir) - STAT_FIXED;
  assign dir_k   = idx - STAT_PREFIX;

  // Byte at position idx of the loaded message, from the snapshots only.
  always_comb begin
    cur_byte = 8'h00;
    case (src)
      SRC_ERR: begin
        case (idx)
          4'd0:    cur_byte = "E";
          4'd1:    cur_byte = "R";
          4'd2:    cur_byte = "R";
          4'd3:    cur_byte = ":";
          4'd4:    cur_byte = "C";
          4'd5:    cur_byte = "M";
          4'd6:    cur_byte = "D";
          4'd7:    cur_byte = ASCII_CR;
          default: cur_byte = ASCII_LF;
        endcase
      end
      SRC_EVT: begin
        case (idx)
          4'd0:    cur_byte = "A";
          4'd1:    cur_byte = "R";
          4'd2:    cur_byte = "R";
          4'd3:    cur_byte = ":";
          4'd4:    cur_byte = tens_char(snap_floor);
          4'd5:    cur_byte = ones_char(snap_floor);
          4'd6:    cur_byte = ASCII_CR;
          default: cur_byte = ASCII_LF;
        endcase
      end
      default: begin
        if (idx < STAT_PREFIX) begin
          case (idx)
            4'd0:    cur_byte = "F";
            4'd1:    cur_byte = ":";
            4'd2:    cur_byte = tens_char(snap_floor);
            4'd3:    cur_byte = ones_char(snap_floor);
            4'd4:    cur_byte = ",";
            4'd5:    cur_byte = "D";
            4'd6:    cur_byte = "I";
            4'd7:    cur_byte = "R";
            default: cur_byte = ":";
          endcase
        end else if (dir_k < dir_len) begin
          cur_byte = dir_char(snap_dir, dir_k);
        end else if (dir_k == dir_len) begin
          cur_byte = ASCII_CR;
        end else begin
          cur_byte = ASCII_LF;
        end
      end
    endcase
  end

  assign TXB_VALID = (state == ST_SEND);
  assign TXB_DATA  = TXB_VALID ? cur_byte : 8'h00;
  assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_msg_sched.sv
// Self-checking bench: per-cycle comparison against a string-level message model.
module tb_uart_msg_sched;

  localparam int T_TICK = 200;

  logic       CLK       = 1'b0;
  logic       RST       = 1'b1;
  logic [5:0] FLOOR     = '0;
  logic [1:0] DIR       = '0;
  logic       ERR_REQ   = 1'b0;
  logic       EVT_REQ   = 1'b0;
  logic [5:0] EVT_FLOOR = '0;
  logic       TX_PAUSE  = 1'b0;
  logic       TXB_READY = 1'b1;
  logic [7:0] TXB_DATA;
  logic       TXB_VALID;
  logic       BUSY;

  always #5 CLK = ~CLK;

  uart_msg_sched #(.T_TICK(T_TICK), .TICK_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLOOR     (FLOOR),
    .DIR       (DIR),
    .ERR_REQ   (ERR_REQ),
    .EVT_REQ   (EVT_REQ),
    .EVT_FLOOR (EVT_FLOOR),
    .TX_PAUSE  (TX_PAUSE),
    .TXB_DATA  (TXB_DATA),
    .TXB_VALID (TXB_VALID),
    .TXB_READY (TXB_READY),
    .BUSY      (BUSY)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending requests, the message text in flight and its cursor.
  bit    m_err, m_evt, m_stat, m_prep;
  int    m_evt_floor = 0;
  int    m_edges = 0;
  int    m_pos = 0;
  int    m_kind = 0;   // 0 error, 1 arrival, 2 status
  string m_msg = "";
  string rx = "";      // bytes the DUT actually handed over
  string crlf;

  function automatic string dir_word(int d);
    case (d)
      0:       return "UP";
      1:       return "STOP";
      2:       return "DOWN";
      default: return "?";
    endcase
  endfunction

  function automatic string esc(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'd13)      r = {r, "\\r"};
      else if (s[i] == 8'd10) r = {r, "\\n"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit n_err, n_evt, n_stat;
    if (RST) begin
      m_err = 0; m_evt = 0; m_stat = 0; m_prep = 0;
      m_msg = ""; m_pos = 0; m_evt_floor = 0; m_edges = 0;
      return;
    end
    n_err = m_err; n_evt = m_evt; n_stat = m_stat;
    m_edges++;
    if (m_msg.len() != 0) begin
      if (TXB_READY) begin
        if (m_pos == m_msg.len() - 1) begin
          if (m_kind == 0) n_err = 0;
          else if (m_kind == 1) n_evt = 0;
          else n_stat = 0;
          m_msg = "";
        end else if (TX_PAUSE) begin
          if (m_kind == 2) n_stat = 0;
          m_msg = "";
        end else begin
          m_pos++;
        end
      end
    end else if (m_prep) begin
      m_prep = 0;
      m_pos = 0;
      if (m_err) begin
        m_kind = 0; m_msg = {"ERR:CMD", crlf};
      end else if (m_evt) begin
        m_kind = 1; m_msg = $sformatf("ARR:%02d%s", m_evt_floor, crlf);
      end else begin
        m_kind = 2; m_msg = $sformatf("F:%02d,DIR:%s%s", FLOOR, dir_word(int'(DIR)), crlf);
      end
    end else if (!TX_PAUSE && (m_err || m_evt || m_stat)) begin
      m_prep = 1;
    end
    if (ERR_REQ) n_err = 1;
    if (EVT_REQ) begin
      n_evt = 1;
      m_evt_floor = int'(EVT_FLOOR);
    end
    if (m_edges % T_TICK == 0) n_stat = 1;
    m_err = n_err; m_evt = n_evt; m_stat = n_stat;
  endtask

  task automatic check_outputs();
    logic       exp_valid, exp_busy;
    logic [7:0] exp_data;
    exp_valid = (m_msg.len() != 0);
    exp_busy  = exp_valid | m_prep;
    exp_data  = exp_valid ? m_msg[m_pos] : 8'h00;
    tests++;
    assert (TXB_VALID === exp_valid) else begin
      fails++; $error("FAIL txb_valid t=%0t got=%b exp=%b", $time, TXB_VALID, exp_valid);
    end
    tests++;
    assert (BUSY === exp_busy) else begin
      fails++; $error("FAIL busy t=%0t got=%b exp=%b", $time, BUSY, exp_busy);
    end
    tests++;
    assert (TXB_DATA === exp_data) else begin
      fails++; $error("FAIL txb_data t=%0t got=%h exp=%h", $time, TXB_DATA, exp_data);
    end
  endtask

  // One clock: record any handshake, step the model, then compare at negedge.
  task automatic cycle();
    if (TXB_VALID === 1'b1 && TXB_READY) rx = $sformatf("%s%c", rx, TXB_DATA);
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Stop one cycle before the edge on which the status period wraps.
  task automatic run_to_tick_edge();
    while ((m_edges + 1) % T_TICK != 0) cycle();
  endtask

  task automatic wait_byte(int kind, int pos, string tag);
    int n = 0;
    while (!(m_msg.len() != 0 && m_kind == kind && m_pos == pos) && n < 40) begin
      cycle(); n++;
    end
    tests++;
    assert (m_msg.len() != 0 && m_kind == kind && m_pos == pos) else begin
      fails++; $error("FAIL %s wait expired got_pos=%0d exp_pos=%0d", tag, m_pos, pos);
    end
  endtask

  task automatic expect_str(string tag, string exp);
    tests++;
    assert (rx == exp) else begin
      fails++; $error("FAIL %s got=\"%s\" exp=\"%s\"", tag, esc(rx), esc(exp));
    end
  endtask

  initial begin
    int n;
    crlf = $sformatf("%c%c", 8'd13, 8'd10);

    // Reset state.
    RST = 1'b1;
    run(2);
    RST = 1'b0;

    // First status after reset, READY always high.
    FLOOR = 6'd7; DIR = 2'b00; TXB_READY = 1'b1;
    rx = "";
    run_to_tick_edge();
    cycle();
    run(20);
    expect_str("stat_up", {"F:07,DIR:UP", crlf});

    // ERR and EVT on the tick edge: strict priority order.
    rx = "";
    run_to_tick_edge();
    ERR_REQ = 1'b1; EVT_REQ = 1'b1; EVT_FLOOR = 6'd32;
    cycle();
    ERR_REQ = 1'b0; EVT_REQ = 1'b0;
    run(50);
    expect_str("priority", {"ERR:CMD", crlf, "ARR:32", crlf, "F:07,DIR:UP", crlf});

    // Status DOWN with READY high one cycle in three.
    FLOOR = 6'd12; DIR = 2'b10;
    rx = "";
    run_to_tick_edge();
    for (int i = 0; i < 81; i++) begin
      TXB_READY = (i % 3 == 2);
      cycle();
    end
    TXB_READY = 1'b1;
    FLOOR = 6'd7; DIR = 2'b00;
    expect_str("stat_down_slow", {"F:12,DIR:DOWN", crlf});

    // Pause while byte 3 of ERR is stalled: byte completes, then abort.
    rx = "";
    ERR_REQ = 1'b1;
    cycle();
    ERR_REQ = 1'b0;
    wait_byte(0, 2, "err_byte3");
    TXB_READY = 1'b0; TX_PAUSE = 1'b1;
    run(5);
    TXB_READY = 1'b1;
    cycle();
    run(10);
    expect_str("err_abort", "ERR");
    TX_PAUSE = 1'b0;
    rx = "";
    run(30);
    expect_str("err_restart", {"ERR:CMD", crlf});

    // Pause during STAT byte 5: status dropped, EVT raised in pause goes after.
    rx = "";
    run_to_tick_edge();
    cycle();
    wait_byte(2, 4, "stat_byte5");
    TX_PAUSE = 1'b1;
    cycle();
    EVT_FLOOR = 6'd5; EVT_REQ = 1'b1;
    cycle();
    EVT_REQ = 1'b0;
    run(10);
    expect_str("stat_abort", "F:07,");
    TX_PAUSE = 1'b0;
    rx = "";
    run(40);
    expect_str("evt_after_pause", {"ARR:05", crlf});

    // Reset mid-EVT: message abandoned, tick counter restarts.
    EVT_FLOOR = 6'd41; EVT_REQ = 1'b1;
    cycle();
    EVT_REQ = 1'b0;
    wait_byte(1, 3, "evt_byte4");
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    rx = "";
    n = 0;
    while (TXB_VALID !== 1'b1 && n < 400) begin
      cycle(); n++;
    end
    tests++;
    assert (n == T_TICK + 2) else begin
      fails++; $error("FAIL first_stat_after_reset got=%0d exp=%0d", n, T_TICK + 2);
    end
    run(20);
    expect_str("stat_after_reset", {"F:07,DIR:UP", crlf});

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      ERR_REQ   = ($urandom_range(39) == 0);
      EVT_REQ   = ($urandom_range(29) == 0);
      EVT_FLOOR = 6'($urandom_range(63));
      if ($urandom_range(24) == 0) TX_PAUSE = ~TX_PAUSE;
      TXB_READY = ($urandom_range(3) != 0);
      FLOOR     = 6'($urandom_range(63));
      DIR       = 2'($urandom_range(3));
      RST       = ($urandom_range(999) == 0);
      cycle();
    end
    ERR_REQ = 1'b0; EVT_REQ = 1'b0; RST = 1'b0; TX_PAUSE = 1'b0; TXB_READY = 1'b1;
    run(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_msg_sched.md
Name: uart_msg_sched

Overview:
- Message scheduler that shares one byte-level UART serializer among three message sources: error report, floor-arrival event, and periodic status.
- Sits between the elevator FSM and the UART bit serializer.
- Owns the 1-second status tick, fixed-priority selection, ASCII message assembly, and pause handling.
- Emits one byte at a time over a valid/ready handshake.

Parameters:
- T_TICK, 50_000_000, clocks per status period.
- TICK_W, 26, width of the tick counter. Must satisfy 2^TICK_W >= T_TICK.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- FLOOR  in  6  current floor (binary), sampled for status messages.
- DIR  in  2  direction: 00 UP, 01 STOP, 10 DOWN, 11 invalid.
- ERR_REQ  in  1  one-cycle pulse requesting an error report.
- EVT_REQ  in  1  one-cycle pulse reporting a floor arrival.
- EVT_FLOOR  in  6  arrival floor, valid only with EVT_REQ.
- TX_PAUSE  in  1  level; halts transmission at the next byte boundary.
- TXB_DATA  out  8  byte offered to the serializer.
- TXB_VALID  out  1  TXB_DATA is valid.
- TXB_READY  in  1  serializer accepts the byte this cycle.
- BUSY  out  1  a message is in progress.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge): TXB_VALID=0, TXB_DATA=8'h00, BUSY=0; all pending flags cleared; tick counter=0; FSM=IDLE. This applies mid-message too: the partial message is abandoned and nothing resumes.
- Tick counter: counts 0..T_TICK-1 and wraps. At wrap it sets stat_pend. It runs during TX_PAUSE. At most one status request is held pending.
- Pending flags:
  - ERR_REQ sets err_pend.
  - EVT_REQ sets evt_pend and overwrites evt_floor (latest wins).
  - A flag clears when the last byte of its message transfers.
  - If a set and a clear land in the same cycle, the set wins.
- Messages (ASCII; nn = two decimal digits of a 6-bit value, 00..63, tens digit = value/10):
  - ERR: "ERR:CMD\r\n", 9 bytes.
  - EVT: "ARR:nn\r\n", 8 bytes; nn from evt_floor.
  - STAT: "F:nn,DIR:" followed by the direction text and "\r\n". Direction text is UP (13 bytes total), STOP (15), DOWN (15), or ? when DIR=11 (12).
- FSM states:
  - IDLE: if TX_PAUSE=0 and any flag is pending, go to LOAD. Priority is ERR > EVT > STAT.
  - LOAD (1 cycle): latch the selected source, length, and snapshots of FLOOR/DIR or evt_floor; set index=0; go to SEND.
  - SEND: TXB_VALID=1. TXB_DATA = byte[index], held stable while TXB_READY=0. On VALID&READY:
    - If index=len-1: go to IDLE (TXB_VALID=0 next cycle).
    - Else if TX_PAUSE=1: go to IDLE (abort).
    - Else: index+1, stay in SEND (back-to-back bytes, no bubble).
- Latency: pending flag seen in IDLE at cycle N → TXB_VALID=1 at cycle N+2. After the last byte, TXB_VALID stays low for at least 2 cycles before the next message.
- Pause rules:
  - TXB_VALID never drops before its handshake completes, even if TX_PAUSE rises.
  - On abort, the STAT flag clears (the status message is dropped). ERR and EVT stay pending and restart from byte 0 after TX_PAUSE falls.
  - Pause asserted in LOAD: the first byte is still presented; the abort takes effect after that byte transfers.
- Non-preemptive: a higher-priority request arriving mid-message waits for the current message to end.
- BUSY=1 in LOAD and SEND.
- Snapshots: FLOOR/DIR changes after LOAD do not affect the message in flight.

Decomposition:
- Package uart_msg_pkg:
  - source encoding (SRC_ERR, SRC_EVT, SRC_STAT);
  - state encoding;
  - message length constants (9, 8, 13, 15, 12);
  - ASCII constants (CR, LF, digit offset 8'd48);
  - DIR codes.
- Sub-module uart_sec_tick: the T_TICK counter producing a one-cycle tick pulse. It uses the same CLK/RST.
- Byte selection is a combinational function of (source, index, snapshots) inside uart_msg_sched.

Test Plan:
- T_TICK=200, FLOOR=7, DIR=00, TXB_READY=1 → at tick: bytes "F:07,DIR:UP\r\n" (13), consecutive, BUSY high throughout, then VALID=0.
- ERR_REQ and EVT_REQ (EVT_FLOOR=32) in the same cycle as a tick → "ERR:CMD\r\n", then "ARR:32\r\n", then "F:..", in that order.
- TXB_READY toggling 1-of-3 cycles during STAT DIR=10, FLOOR=12 → "F:12,DIR:DOWN\r\n" with TXB_DATA stable whenever VALID&!READY.
- TX_PAUSE rises during byte 3 of ERR with READY held low for 5 cycles → byte 3 completes, VALID falls; after pause release, ERR restarts with "E".
- TX_PAUSE during STAT byte 5 → STAT dropped and not resent until the next tick; EVT_REQ during the pause is sent after release.
- RST=1 for 1 cycle mid-EVT message → next cycle VALID=0, BUSY=0, no pending, tick counter restarts; first status arrives T_TICK cycles later.
